// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and load/store.
// MEM has priority; a streak counter bounds how long IF can be passed over.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STREAK_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_valid,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_stall,
    output logic              port_req,
    output logic              port_we,
    output logic [ADDR_W-1:0] port_addr,
    output logic [DATA_W-1:0] port_wdata,
    input  logic              port_ready,
    input  logic [DATA_W-1:0] port_rdata,
    output logic              arb_busy
);

    localparam int unsigned STREAK_W = $clog2(STREAK_MAX + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_IF  = 2'd1,
        BUSY_MEM = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                drop_q, drop_d;
    logic                if_valid_d, mem_valid_d, port_req_d, port_we_d, arb_busy_d;
    logic [DATA_W-1:0]   if_rdata_d, mem_rdata_d, port_wdata_d;
    logic [ADDR_W-1:0]   port_addr_d;
    logic                if_elig, mem_elig, grant_if;

    // A requester still shows its old request during its valid cycle; never re-issue it.
    assign if_elig  = if_req & ~if_valid & ~if_flush;
    assign mem_elig = mem_req & ~mem_valid;
    assign grant_if = if_elig & (~mem_elig | (streak_q == STREAK_W'(STREAK_MAX)));

    assign if_stall  = if_req & ~if_valid;
    assign mem_stall = mem_req & ~mem_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            streak_q   <= '0;
            drop_q     <= 1'b0;
            if_valid   <= 1'b0;
            if_rdata   <= '0;
            mem_valid  <= 1'b0;
            mem_rdata  <= '0;
            port_req   <= 1'b0;
            port_we    <= 1'b0;
            port_addr  <= '0;
            port_wdata <= '0;
            arb_busy   <= 1'b0;
        end else begin
            state_q    <= state_d;
            streak_q   <= streak_d;
            drop_q     <= drop_d;
            if_valid   <= if_valid_d;
            if_rdata   <= if_rdata_d;
            mem_valid  <= mem_valid_d;
            mem_rdata  <= mem_rdata_d;
            port_req   <= port_req_d;
            port_we    <= port_we_d;
            port_addr  <= port_addr_d;
            port_wdata <= port_wdata_d;
            arb_busy   <= arb_busy_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        streak_d     = streak_q;
        drop_d       = drop_q;
        if_valid_d   = 1'b0;
        mem_valid_d  = 1'b0;
        if_rdata_d   = if_rdata;
        mem_rdata_d  = mem_rdata;
        port_req_d   = port_req;
        port_we_d    = port_we;
        port_addr_d  = port_addr;
        port_wdata_d = port_wdata;

        case (state_q)
            IDLE: begin
                if (grant_if) begin
                    state_d      = BUSY_IF;
                    streak_d     = '0;
                    port_req_d   = 1'b1;
                    port_we_d    = 1'b0;
                    port_addr_d  = if_addr;
                    port_wdata_d = '0;
                end else if (mem_elig) begin
                    state_d      = BUSY_MEM;
                    port_req_d   = 1'b1;
                    port_we_d    = mem_we;
                    port_addr_d  = mem_addr;
                    port_wdata_d = mem_wdata;
                    // Only count MEM wins that actually held off a waiting fetch.
                    if (!if_elig) begin
                        streak_d = '0;
                    end else if (streak_q != STREAK_W'(STREAK_MAX)) begin
                        streak_d = streak_q + STREAK_W'(1);
                    end
                end
            end
            BUSY_IF: begin
                if (if_flush) begin
                    drop_d = 1'b1;
                end
                if (port_ready) begin
                    state_d    = IDLE;
                    port_req_d = 1'b0;
                    drop_d     = 1'b0;
                    // A flushed fetch still completes on the port but is discarded here.
                    if (!(drop_q || if_flush)) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = port_rdata;
                    end
                end
            end
            BUSY_MEM: begin
                if (port_ready) begin
                    state_d     = IDLE;
                    port_req_d  = 1'b0;
                    mem_valid_d = 1'b1;
                    if (!port_we) begin
                        mem_rdata_d = port_rdata;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        arb_busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a small memory model answers the port,
// expected port transactions and completions are queued when stimulus is driven.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req, if_flush, if_valid, if_stall;
    logic [31:0] if_addr, if_rdata;
    logic        mem_req, mem_we, mem_valid, mem_stall;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        port_req, port_we, arb_busy;
    logic        port_ready = 1'b0;
    logic [31:0] port_addr, port_wdata;
    logic [31:0] port_rdata = '0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STREAK_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_valid(if_valid), .if_rdata(if_rdata), .if_stall(if_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_valid(mem_valid), .mem_rdata(mem_rdata), .mem_stall(mem_stall),
        .port_req(port_req), .port_we(port_we), .port_addr(port_addr),
        .port_wdata(port_wdata), .port_ready(port_ready), .port_rdata(port_rdata),
        .arb_busy(arb_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } ptx_t;

    int          n_vec = 0;
    int          n_miss = 0;
    int unsigned cyc = 0;
    int          ready_dly = 0;
    int          wait_cnt = 0;
    ptx_t        port_q[$];
    logic [31:0] if_q[$];
    logic [31:0] mem_q[$];
    logic [31:0] mem_model[logic [31:0]];
    logic [31:0] if_rdata_model = '0;
    logic [31:0] mem_rdata_model = '0;
    ptx_t        pexp, phold;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        return mem_model.exists(a) ? mem_model[a] : (a ^ 32'h5A5A_0000);
    endfunction

    // Memory responder: checks each port transaction against the expected queue and
    // that the port bus stays stable until it is accepted.
    always @(posedge clk) begin
        #1;
        if (!port_req) begin
            port_ready = 1'b0;
            wait_cnt   = 0;
        end else begin
            if (wait_cnt == 0) begin
                if (port_q.size() == 0) begin
                    check("port_unexpected_txn", 32'(1), 32'(0));
                end else begin
                    pexp = port_q.pop_front();
                    check("port_addr", port_addr, pexp.addr);
                    check("port_we", 32'(port_we), 32'(pexp.we));
                    check("port_wdata", port_wdata, pexp.wdata);
                end
                phold = '{port_addr, port_we, port_wdata};
            end else begin
                check("port_addr_hold", port_addr, phold.addr);
                check("port_we_hold", 32'(port_we), 32'(phold.we));
                check("port_wdata_hold", port_wdata, phold.wdata);
            end
            port_rdata = rd_model(port_addr);
            port_ready = (wait_cnt >= ready_dly);
            wait_cnt++;
        end
    end

    // Completion monitors pop the scoreboards.
    always @(negedge clk) begin
        if (rst_n && if_valid) begin
            if (if_q.size() == 0) check("if_valid_unexpected", 32'(1), 32'(0));
            else check("if_rdata", if_rdata, if_q.pop_front());
        end
        if (rst_n && mem_valid) begin
            if (mem_q.size() == 0) check("mem_valid_unexpected", 32'(1), 32'(0));
            else check("mem_rdata", mem_rdata, mem_q.pop_front());
        end
    end

    task automatic chk_reset_outputs(input string tag);
        check({tag, "_port_req"}, 32'(port_req), 32'(0));
        check({tag, "_port_we"}, 32'(port_we), 32'(0));
        check({tag, "_port_addr"}, port_addr, 32'(0));
        check({tag, "_port_wdata"}, port_wdata, 32'(0));
        check({tag, "_if_valid"}, 32'(if_valid), 32'(0));
        check({tag, "_if_rdata"}, if_rdata, 32'(0));
        check({tag, "_mem_valid"}, 32'(mem_valid), 32'(0));
        check({tag, "_mem_rdata"}, mem_rdata, 32'(0));
        check({tag, "_arb_busy"}, 32'(arb_busy), 32'(0));
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic do_fetch(input logic [31:0] addr, input int lat);
        logic [31:0] exp;
        int unsigned t0;
        bit          ok;
        exp = rd_model(addr);
        if_q.push_back(exp);
        port_q.push_back('{addr, 1'b0, 32'h0});
        if_addr = addr;
        if_req  = 1'b1;
        t0      = cyc;
        ok      = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (if_valid) begin
                ok = 1'b1;
                break;
            end
            check("if_stall_pending", 32'(if_stall), 32'(1));
        end
        check("if_fetch_timeout", 32'(ok), 32'(1));
        check("if_latency", cyc - t0, 32'(lat));
        check("if_stall_at_valid", 32'(if_stall), 32'(0));
        if_rdata_model = exp;
        @(posedge clk); #1;
        if_req = 1'b0;
    endtask

    task automatic do_mem(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                          input int dly, input int lat);
        int unsigned t0;
        bit          ok;
        if (we) begin
            mem_q.push_back(mem_rdata_model);
            mem_model[addr] = wdata;
        end else begin
            mem_rdata_model = rd_model(addr);
            mem_q.push_back(mem_rdata_model);
        end
        port_q.push_back('{addr, we, we ? wdata : 32'h0});
        ready_dly = dly;
        mem_addr  = addr;
        mem_we    = we;
        mem_wdata = wdata;
        mem_req   = 1'b1;
        t0        = cyc;
        ok        = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_valid) begin
                ok = 1'b1;
                break;
            end
            check("mem_stall_pending", 32'(mem_stall), 32'(1));
        end
        check("mem_timeout", 32'(ok), 32'(1));
        check("mem_latency", cyc - t0, 32'(lat));
        check("mem_stall_at_valid", 32'(mem_stall), 32'(0));
        @(posedge clk); #1;
        mem_req = 1'b0;
        mem_we  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1);
    end

    initial begin
        bit ok;
        if_req = 1'b0; if_flush = 1'b0; if_addr = '0;
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;

        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Lone fetch, memory answers in the first port cycle.
        mem_model[32'h100] = 32'hDEAD_BEEF;
        ready_dly = 0;
        do_fetch(32'h100, 2);

        // MEM streak vs waiting IF: expected port order M0 M1 M2 M3 I M4.
        ready_dly = 0;
        for (int k = 0; k < 4; k++) begin
            port_q.push_back('{32'h2000 + 32'(4 * k), 1'b0, 32'h0});
            mem_q.push_back(rd_model(32'h2000 + 32'(4 * k)));
        end
        port_q.push_back('{32'h3000, 1'b0, 32'h0});
        if_q.push_back(rd_model(32'h3000));
        port_q.push_back('{32'h2010, 1'b0, 32'h0});
        mem_q.push_back(rd_model(32'h2010));
        mem_rdata_model = rd_model(32'h2010);
        if_rdata_model  = rd_model(32'h3000);
        fork
            begin : mem_thread
                bit mok;
                mem_we  = 1'b0;
                mem_req = 1'b1;
                for (int k = 0; k < 5; k++) begin
                    mem_addr = 32'h2000 + 32'(4 * k);
                    mok = 1'b0;
                    for (int i = 0; i < 40; i++) begin
                        @(negedge clk);
                        if (mem_valid) begin
                            mok = 1'b1;
                            break;
                        end
                    end
                    check("arb_mem_timeout", 32'(mok), 32'(1));
                    @(posedge clk); #1;
                end
                mem_req = 1'b0;
            end
            begin : if_thread
                bit iok;
                // IF backs off in MEM valid cycles, so only real grant decisions see it waiting.
                if_addr = 32'h3000;
                if_req  = 1'b1;
                iok     = 1'b0;
                for (int i = 0; i < 100; i++) begin
                    @(posedge clk); #1;
                    if (if_valid) begin
                        iok = 1'b1;
                        break;
                    end
                    if_req = ~mem_valid;
                end
                check("arb_if_timeout", 32'(iok), 32'(1));
                @(posedge clk); #1;
                if_req = 1'b0;
            end
        join
        check("arb_port_q_drained", 32'(port_q.size()), 32'(0));

        // Store with a slow memory; load data register must not move.
        do_mem(32'h40, 1'b1, 32'hCAFE_F00D, 3, 5);
        do_mem(32'h40, 1'b0, 32'h0, 0, 2);

        // Flush while the fetch is on the port: transaction completes, result dropped.
        ready_dly = 2;
        port_q.push_back('{32'h200, 1'b0, 32'h0});
        if_addr = 32'h200;
        if_req  = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (port_req) begin
                ok = 1'b1;
                break;
            end
        end
        check("flush_start_timeout", 32'(ok), 32'(1));
        @(posedge clk); #1;
        if_flush = 1'b1;
        if_req   = 1'b0;
        @(posedge clk); #1;
        if_flush = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!arb_busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("flush_done_timeout", 32'(ok), 32'(1));
        check("flush_no_if_valid", 32'(if_valid), 32'(0));
        check("flush_if_rdata_kept", if_rdata, if_rdata_model);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        ready_dly = 0;
        do_fetch(32'h300, 2);

        // Async reset while a load waits on the port.
        ready_dly = 6;
        port_q.push_back('{32'h80, 1'b0, 32'h0});
        mem_we   = 1'b0;
        mem_addr = 32'h80;
        mem_req  = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (port_req) begin
                ok = 1'b1;
                break;
            end
        end
        check("arst_start_timeout", 32'(ok), 32'(1));
        #2;
        rst_n   = 1'b0;
        mem_req = 1'b0;
        #1;
        chk_reset_outputs("arst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        if_rdata_model  = '0;
        mem_rdata_model = '0;
        repeat (6) @(negedge clk);
        check("arst_after_busy", 32'(arb_busy), 32'(0));
        check("arst_after_port_req", 32'(port_req), 32'(0));
        @(posedge clk); #1;
        do_mem(32'h84, 1'b0, 32'h0, 1, 3);

        repeat (3) @(negedge clk);
        check("end_port_q_empty", 32'(port_q.size()), 32'(0));
        check("end_if_q_empty", 32'(if_q.size()), 32'(0));
        check("end_mem_q_empty", 32'(mem_q.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
